branch_predictor: RTL and testbench



---
 rtl/branch_predictor.sv | 135 +++++++++++++
 tb/tb_branch_predictor.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Gshare direction predictor with direct-mapped BTB; define BP_STATS_EN to add lookup/mispredict counters.
// Latency: prediction is combinational from fetch_pc; training and GHR repair are visible after the next edge.
// Backpressure: none; updates are always accepted, fetch_stall only suppresses the speculative GHR shift.
module branch_predictor #(
  parameter int BTB_IDX_BITS = 5,
  parameter int GHR_BITS     = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fetch_valid,
  input  logic                fetch_stall,
  input  logic [31:0]         fetch_pc,
  output logic [31:0]         pred_next_pc,
  output logic                pred_taken,
  output logic [GHR_BITS-1:0] pred_ghr,
  input  logic                upd_valid,
  input  logic                upd_is_branch,
  input  logic                upd_is_jump,
  input  logic [31:0]         upd_pc,
  input  logic                upd_taken,
  input  logic [31:0]         upd_target,
  input  logic [GHR_BITS-1:0] upd_ghr,
  input  logic                upd_mispredict
`ifdef BP_STATS_EN
  ,
  output logic [31:0]         stat_lookups,
  output logic [31:0]         stat_mispredicts
`endif
);

  localparam int BTB_N = 1 << BTB_IDX_BITS;
  localparam int PHT_N = 1 << GHR_BITS;
  localparam int TAG_W = 30 - BTB_IDX_BITS;

  logic [BTB_N-1:0]        btb_valid;
  logic [BTB_N-1:0]        btb_jump;
  logic [TAG_W-1:0]        btb_tag    [BTB_N];
  logic [31:0]             btb_target [BTB_N];
  logic [1:0]              pht        [PHT_N];
  logic [GHR_BITS-1:0]     ghr;
  logic [GHR_BITS-1:0]     ghr_nxt;

  logic [BTB_IDX_BITS-1:0] bidx;
  logic [BTB_IDX_BITS-1:0] ubidx;
  logic [TAG_W-1:0]        ftag;
  logic [TAG_W-1:0]        utag;
  logic [GHR_BITS-1:0]     pidx;
  logic [GHR_BITS-1:0]     upidx;
  logic                    hit;
  logic                    entry_jump;
  logic                    spec_shift;
  logic                    upd_br;
  logic                    upd_jmp;
  logic                    btb_wr;
  logic [1:0]              ctr;
  logic [1:0]              ctr_nxt;
  logic                    unused_pc_bits;

  assign bidx         = fetch_pc[BTB_IDX_BITS+1:2];
  assign ftag         = fetch_pc[31:BTB_IDX_BITS+2];
  assign pidx         = fetch_pc[GHR_BITS+1:2] ^ ghr;
  assign hit          = btb_valid[bidx] && (btb_tag[bidx] == ftag);
  assign entry_jump   = btb_jump[bidx];
  assign pred_taken   = hit && (entry_jump || pht[pidx][1]);
  assign pred_next_pc = pred_taken ? btb_target[bidx] : fetch_pc + 32'd4;
  assign pred_ghr     = ghr;
  assign spec_shift   = fetch_valid && !fetch_stall && hit && !entry_jump;

  assign upd_br  = upd_valid && upd_is_branch;
  assign upd_jmp = upd_valid && upd_is_jump;
  assign btb_wr  = upd_jmp || (upd_br && upd_taken);
  assign ubidx   = upd_pc[BTB_IDX_BITS+1:2];
  assign utag    = upd_pc[31:BTB_IDX_BITS+2];
  assign upidx   = upd_pc[GHR_BITS+1:2] ^ upd_ghr;
  assign ctr     = pht[upidx];

  // Instructions are word aligned; the byte offset never selects anything.
  assign unused_pc_bits = ^{fetch_pc[1:0], upd_pc[1:0]};

  always_comb begin
    ctr_nxt = ctr;
    if (upd_taken && ctr != 2'b11)
      ctr_nxt = ctr + 2'b01;
    else if (!upd_taken && ctr != 2'b00)
      ctr_nxt = ctr - 2'b01;
  end

  // Mispredict repair overrides the speculative shift from this cycle's fetch.
  always_comb begin
    ghr_nxt = ghr;
    if ((upd_br || upd_jmp) && upd_mispredict)
      ghr_nxt = upd_jmp ? upd_ghr : {upd_ghr[GHR_BITS-2:0], upd_taken};
    else if (spec_shift)
      ghr_nxt = {ghr[GHR_BITS-2:0], pred_taken};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btb_valid <= '0;
      btb_jump  <= '0;
      ghr       <= '0;
      for (int i = 0; i < BTB_N; i++) begin
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
      end
      for (int i = 0; i < PHT_N; i++)
        pht[i] <= 2'b01;
    end else begin
      ghr <= ghr_nxt;
      if (upd_br)
        pht[upidx] <= ctr_nxt;
      if (btb_wr) begin
        btb_valid[ubidx]  <= 1'b1;
        btb_jump[ubidx]   <= upd_is_jump;
        btb_tag[ubidx]    <= utag;
        btb_target[ubidx] <= upd_target;
      end
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_lookups     <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (fetch_valid && !fetch_stall)
        stat_lookups <= stat_lookups + 32'd1;
      if (upd_valid && upd_mispredict)
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboarded bench for branch_predictor: directed scenarios then random fetch/update traffic
// against a table-level model of the BTB, PHT and history.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_valid, fetch_stall;
  logic [31:0] fetch_pc;
  logic [31:0] pred_next_pc;
  logic        pred_taken;
  logic [4:0]  pred_ghr;
  logic        upd_valid, upd_is_branch, upd_is_jump, upd_taken, upd_mispredict;
  logic [31:0] upd_pc, upd_target;
  logic [4:0]  upd_ghr;

  always #5 clk = ~clk;

  branch_predictor #(.BTB_IDX_BITS(5), .GHR_BITS(5)) dut (
    .clk(clk), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_stall(fetch_stall), .fetch_pc(fetch_pc),
    .pred_next_pc(pred_next_pc), .pred_taken(pred_taken), .pred_ghr(pred_ghr),
    .upd_valid(upd_valid), .upd_is_branch(upd_is_branch), .upd_is_jump(upd_is_jump),
    .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_ghr(upd_ghr), .upd_mispredict(upd_mispredict)
  );

  typedef struct packed {
    logic        taken;
    logic [31:0] npc;
    logic [4:0]  ghr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  // Reference model: one slot per BTB index remembering which instruction owns it.
  bit          m_vld [32];
  bit          m_jmp [32];
  logic [31:0] m_pc  [32];
  logic [31:0] m_tgt [32];
  int          m_pht [32];
  int          m_ghr;

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) begin
      m_vld[i] = 0; m_jmp[i] = 0; m_pc[i] = '0; m_tgt[i] = '0; m_pht[i] = 1;
    end
    m_ghr = 0;
  endfunction

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) & 32'd31);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_vld[slot(pc)] && (m_pc[slot(pc)] == pc);
  endfunction

  function automatic exp_t m_predict(input logic [31:0] pc);
    exp_t r;
    int   p;
    p       = int'(((pc >> 2) ^ 32'(m_ghr)) & 32'd31);
    r.taken = m_hit(pc) && (m_jmp[slot(pc)] || m_pht[p] >= 2);
    r.npc   = r.taken ? m_tgt[slot(pc)] : pc + 32'd4;
    r.ghr   = 5'(m_ghr);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // One cycle of stimulus: drive, push the expected prediction, advance the model past the edge.
  task automatic step(input bit fv, input bit fs, input logic [31:0] fpc,
                      input bit uv, input bit ub, input bit uj, input logic [31:0] upc,
                      input bit ut, input logic [31:0] utgt, input logic [4:0] ughr, input bit um);
    exp_t e;
    int   ng, q, b;
    @(posedge clk);
    #2;
    fetch_valid = fv; fetch_stall = fs; fetch_pc = fpc;
    upd_valid = uv; upd_is_branch = ub; upd_is_jump = uj; upd_pc = upc;
    upd_taken = ut; upd_target = utgt; upd_ghr = ughr; upd_mispredict = um;
    e = m_predict(fpc);
    if (fv) exp_q.push_back(e);
    ng = m_ghr;
    if (fv && !fs && m_hit(fpc) && !m_jmp[slot(fpc)])
      ng = ((m_ghr << 1) | int'(e.taken)) & 31;
    if (uv && (ub || uj)) begin
      if (ub) begin
        q = int'(((upc >> 2) ^ 32'(ughr)) & 32'd31);
        if (ut) m_pht[q] = (m_pht[q] == 3) ? 3 : m_pht[q] + 1;
        else    m_pht[q] = (m_pht[q] == 0) ? 0 : m_pht[q] - 1;
      end
      if (uj || ut) begin
        b = slot(upc);
        m_vld[b] = 1; m_jmp[b] = uj; m_pc[b] = upc; m_tgt[b] = utgt;
      end
      if (um) ng = uj ? int'(ughr) : ((int'(ughr) << 1) | int'(ut)) & 31;
    end
    m_ghr = ng;
  endtask

  function automatic logic [31:0] rand_pc();
    return 32'($urandom_range(0, 3)) * 32'h80 + 32'($urandom_range(0, 31)) * 32'd4;
  endfunction

  // Monitor: compares every live prediction against the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && fetch_valid) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_empty: prediction for pc %h with no expectation queued", fetch_pc);
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_taken", 32'(pred_taken), 32'(mon_e.taken));
          check("sb_next_pc", pred_next_pc, mon_e.npc);
          check("sb_ghr", 32'(pred_ghr), 32'(mon_e.ghr));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    bit kind_b, kind_j, kind_n;
    int kind;
    reset = 1'b1;
    fetch_valid = 0; fetch_stall = 0; fetch_pc = '0;
    upd_valid = 0; upd_is_branch = 0; upd_is_jump = 0; upd_pc = '0;
    upd_taken = 0; upd_target = '0; upd_ghr = '0; upd_mispredict = 0;
    m_reset();
    #12 reset = 1'b0;

    // Reset state
    step(1, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("rst_taken", 32'(pred_taken), 32'd0);
    check("rst_next_pc", pred_next_pc, 32'h104);
    check("rst_ghr", 32'(pred_ghr), 32'd0);

    // Jump allocation
    step(0, 0, 0, 1, 0, 1, 32'h100, 1, 32'h200, 5'd0, 1);
    step(1, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("jal_taken", 32'(pred_taken), 32'd1);
    check("jal_next_pc", pred_next_pc, 32'h200);
    check("jal_ghr", 32'(pred_ghr), 32'd0);

    // Counter training taken twice, then saturating not-taken
    step(0, 0, 0, 1, 1, 0, 32'h40, 1, 32'h80, 5'd0, 0);
    step(0, 0, 0, 1, 1, 0, 32'h40, 1, 32'h80, 5'd0, 0);
    step(1, 0, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("br_tk_next_pc", pred_next_pc, 32'h80);
    for (int i = 0; i < 4; i++)
      step(0, 0, 0, 1, 1, 0, 32'h40, 0, 32'h80, 5'd0, 0);
    step(0, 0, 0, 1, 0, 1, 32'h100, 1, 32'h200, 5'd0, 1);
    step(1, 0, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("br_nt_taken", 32'(pred_taken), 32'd0);
    check("br_nt_next_pc", pred_next_pc, 32'h44);

    // Aliasing index, different tag
    step(1, 0, 32'hC0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("alias_next_pc", pred_next_pc, 32'hC4);

    // Speculative shift loses to same-cycle repair
    step(0, 0, 0, 1, 0, 1, 32'h100, 1, 32'h200, 5'd3, 1);
    step(1, 0, 32'h40, 1, 1, 0, 32'h500, 0, 32'h600, 5'd1, 1);
    #1;
    check("spec_ghr_before", 32'(pred_ghr), 32'd3);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("repair_ghr", 32'(pred_ghr), 32'd2);

    // Asynchronous reset between edges
    step(1, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("pre_arst_taken", 32'(pred_taken), 32'd1);
    @(negedge clk);
    #1;
    fetch_valid = 0;
    reset = 1'b1;
    #1;
    check("arst_taken", 32'(pred_taken), 32'd0);
    check("arst_next_pc", pred_next_pc, 32'h104);
    m_reset();
    exp_q.delete();
    @(negedge clk);
    #1 reset = 1'b0;
    step(1, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("post_arst_miss", 32'(pred_taken), 32'd0);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      kind   = int'($urandom_range(0, 3));
      kind_b = (kind == 1);
      kind_j = (kind == 2);
      kind_n = (kind == 0);
      step($urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0, rand_pc(),
           !kind_n, kind_b, kind_j, rand_pc(),
           kind_j ? 1'b1 : 1'($urandom_range(0, 1)), rand_pc(),
           5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
